sum_uart_tx: RTL

Serial output stage for the 16-point sum path. Captures each 12-bit signed sum and its one-cycle sync pulse from the accumulator directly upstream, and buffers up to 4 results in a FIFO. Transmits each result as a two-byte 8N1 UART record on a single `tx` line, so the sums can be logged off-chip.

---
 rtl/sum_uart_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sum_uart_tx.sv
// Serial output stage for the 16-point sum path: a 4-entry FIFO of 12-bit sums
// drained as two-byte 8N1 UART records {4'hA, d[11:8]}, d[7:0] on a single tx line.
module sum_uart_tx #(
  parameter int BAUD_DIV = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic [11:0] data_in,
  input  logic        syn_in,
  output logic        tx,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [11:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [11:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  lo_q, lo_d;
  logic        sel_q, sel_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        pop;
  logic        push;
  logic        baud_end;
  logic [11:0] head;

  assign head     = fifo_q[rd_ptr_q];
  assign baud_end = (baud_q == BAUD_LAST);
  assign pop      = (state_q == IDLE) && (count_q != 3'd0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push     = syn_in && ((count_q != 3'd4) || pop);

  // Storage carries no reset; emptiness is defined by the count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      baud_q   <= 12'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      lo_q     <= 8'd0;
      sel_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      lo_q     <= lo_d;
      sel_q    <= sel_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    lo_d     = lo_q;
    sel_d    = sel_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = {4'hA, head[11:8]};
          lo_d    = head[7:0];
          sel_d   = 1'b0;
          baud_d  = 12'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = 12'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = 12'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = 12'd0;
          if (!sel_q) begin
            shift_d = lo_q;
            sel_d   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line lines up with bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != 3'd0);
    ovf_d  = syn_in && !push;
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
